// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST driver.
// Holds the FSM state enum, the LFSR/MISR polynomial, the default operand seeds,
// the flag-packing order fed into the MISR, and the common shift helper.
package alu_bist_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      CAPTURE = 3'd2,
      CHECK   = 3'd3,
      DONE    = 3'd4
   } bist_state_e;

   localparam logic [31:0] BIST_POLY      = 32'h0040_0007;
   localparam logic [31:0] DEFAULT_SEED_A = 32'hE56D_2A62;
   localparam logic [31:0] DEFAULT_SEED_B = 32'h87ED_2F62;

   // Flags are folded into the low nibble of the MISR input in this order (MSB first).
   typedef struct packed {
      logic slt;
      logic ovf;
      logic zero;
      logic cout;
   } alu_flags_t;

   // Galois-style shift shared by the operand LFSRs and the MISR.
   function automatic logic [31:0] bist_shift(input logic [31:0] v);
      return {v[30:0], 1'b0} ^ (v[31] ? BIST_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit operand LFSR: reloads seed_i on load_i, otherwise advances one step on step_i.
// Latency: new value visible one cycle after load_i/step_i; no backpressure, load wins over step.
// Ports: clk, rst_n (async active-low, resets to RESET_SEED), load_i, step_i, seed_i[31:0], state_o[31:0].
module bist_lfsr32
   import alu_bist_pkg::*;
#(
   parameter logic [31:0] RESET_SEED = DEFAULT_SEED_A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [31:0] seed_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = seed_i;
      end else if (step_i) begin
         state_d = bist_shift(state_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/alu_bist_driver.sv
// ALU BIST driver: LFSR operands + opcode sweep into the ALU, MISR-compresses result and flags, golden compare.
// Latency: done rises on the (NUM_VECTORS*(SETTLE_CYCLES+1)+2)-th edge counting the start-sampling edge as the first.
// Backpressure: none; start is only honoured in IDLE/DONE. Optional abort input under macro ALU_BIST_ABORT_EN.
// Ports: clk, rst_n, start, [abort], busy, done, pass, alu_A/alu_B/alu_OpCode (to ALU),
//        alu_Result/alu_Cout/alu_ZeroFlag/alu_OverflowFlag/alu_SLTFlag (from ALU), vec_count, signature.
module alu_bist_driver
   import alu_bist_pkg::*;
#(
   parameter int unsigned NUM_VECTORS   = 48,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [31:0] SEED_A        = DEFAULT_SEED_A,
   parameter logic [31:0] SEED_B        = DEFAULT_SEED_B,
   parameter logic [31:0] GOLDEN_SIG    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
`ifdef ALU_BIST_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] alu_A,
   output logic [31:0] alu_B,
   output logic [3:0]  alu_OpCode,
   input  logic [31:0] alu_Result,
   input  logic        alu_Cout,
   input  logic        alu_ZeroFlag,
   input  logic        alu_OverflowFlag,
   input  logic        alu_SLTFlag,
   output logic [15:0] vec_count,
   output logic [31:0] signature
);

   localparam logic [15:0] NV          = 16'(NUM_VECTORS);
   localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   bist_state_e state_q, state_d;
   logic [3:0]  settle_q, settle_d;
   logic [15:0] vc_q, vc_d, vc_inc;
   logic [31:0] sig_q, sig_d;
   logic [3:0]  op_q, op_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        lfsr_load, lfsr_step;
   alu_flags_t  flags;

   assign flags = '{slt: alu_SLTFlag, ovf: alu_OverflowFlag, zero: alu_ZeroFlag, cout: alu_Cout};

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      vc_d      = vc_q;
      sig_d     = sig_q;
      op_d      = op_q;
      pass_d    = pass_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      // Saturating increment keeps vec_count from ever passing NUM_VECTORS.
      vc_inc    = (vc_q >= NV) ? vc_q : vc_q + 16'd1;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               lfsr_load = 1'b1;
               op_d      = 4'd0;
               vc_d      = 16'd0;
               sig_d     = 32'd0;
               pass_d    = 1'b0;
               settle_d  = 4'd0;
               state_d   = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = 4'd0;
               state_d  = CAPTURE;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         CAPTURE: begin
            sig_d     = bist_shift(sig_q) ^ alu_Result ^ {28'b0, flags};
            vc_d      = vc_inc;
            op_d      = vc_inc[3:0];
            lfsr_step = 1'b1;
            state_d   = (vc_q == LAST_VEC) ? CHECK : SETTLE;
         end
         CHECK: begin
            pass_d  = (sig_q == GOLDEN_SIG);
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

`ifdef ALU_BIST_ABORT_EN
      // Abort overrides everything above; progress counters and signature stay frozen.
      if (abort && busy_q) begin
         state_d   = IDLE;
         settle_d  = 4'd0;
         vc_d      = vc_q;
         sig_d     = sig_q;
         op_d      = op_q;
         pass_d    = 1'b0;
         lfsr_load = 1'b0;
         lfsr_step = 1'b0;
      end
`endif

      busy_d = (state_d == SETTLE) || (state_d == CAPTURE) || (state_d == CHECK);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         settle_q <= 4'd0;
         vc_q     <= 16'd0;
         sig_q    <= 32'd0;
         op_q     <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         vc_q     <= vc_d;
         sig_q    <= sig_d;
         op_q     <= op_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   bist_lfsr32 #(.RESET_SEED(SEED_A)) u_lfsr_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (lfsr_load),
      .step_i  (lfsr_step),
      .seed_i  (SEED_A),
      .state_o (alu_A)
   );

   bist_lfsr32 #(.RESET_SEED(SEED_B)) u_lfsr_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (lfsr_load),
      .step_i  (lfsr_step),
      .seed_i  (SEED_B),
      .state_o (alu_B)
   );

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign alu_OpCode = op_q;
   assign vec_count  = vc_q;
   assign signature  = sig_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: one default instance driven by a behavioural ALU, plus two
// two-vector instances on a constant stub ALU (golden match / mismatch). Edges are counted
// with the start-sampling edge as edge 1.
module tb_alu_bist_driver;

   localparam logic [31:0] POLY = 32'h0040_0007;
   localparam logic [31:0] SA   = 32'hE56D_2A62;
   localparam logic [31:0] SB   = 32'h87ED_2F62;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
`ifdef ALU_BIST_ABORT_EN
   logic abort = 1'b0;
   logic abort_off = 1'b0;
`endif

   always #5 clk = ~clk;

   // default instance
   logic        d_busy, d_done, d_pass, d_cout, d_zero, d_ovf, d_slt;
   logic [31:0] d_A, d_B, d_res, d_sig;
   logic [3:0]  d_op;
   logic [15:0] d_vc;
   // two-vector instances
   logic        p_busy, p_done, p_pass, f_busy, f_done, f_pass;
   logic [31:0] p_A, p_B, p_sig, f_A, f_B, f_sig;
   logic [3:0]  p_op, f_op;
   logic [15:0] p_vc, f_vc;

   int total = 0;
   int bad   = 0;
   int ecount;

   function automatic logic [31:0] shf(input logic [31:0] v);
      return {v[30:0], 1'b0} ^ (v[31] ? POLY : 32'h0);
   endfunction

   // Behavioural ALU: returns {slt, ovf, zero, cout, result}.
   function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic c, v, lt;
      c  = 1'b0;
      v  = 1'b0;
      lt = ($signed(a) < $signed(b));
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd6: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'd7:  r = {31'b0, lt};
         4'd12: r = ~(a | b);
         default: r = a ^ b;
      endcase
      return {lt, v, (r == 32'h0), c, r};
   endfunction

   assign {d_slt, d_ovf, d_zero, d_cout, d_res} = alu_fn(d_A, d_B, d_op);

   alu_bist_driver dut_def (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ALU_BIST_ABORT_EN
      .abort(abort),
`endif
      .busy(d_busy), .done(d_done), .pass(d_pass),
      .alu_A(d_A), .alu_B(d_B), .alu_OpCode(d_op),
      .alu_Result(d_res), .alu_Cout(d_cout), .alu_ZeroFlag(d_zero),
      .alu_OverflowFlag(d_ovf), .alu_SLTFlag(d_slt),
      .vec_count(d_vc), .signature(d_sig)
   );

   alu_bist_driver #(.NUM_VECTORS(2), .SETTLE_CYCLES(1), .GOLDEN_SIG(32'h8040_0007)) dut_p (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ALU_BIST_ABORT_EN
      .abort(abort_off),
`endif
      .busy(p_busy), .done(p_done), .pass(p_pass),
      .alu_A(p_A), .alu_B(p_B), .alu_OpCode(p_op),
      .alu_Result(32'h8000_0000), .alu_Cout(1'b0), .alu_ZeroFlag(1'b0),
      .alu_OverflowFlag(1'b0), .alu_SLTFlag(1'b0),
      .vec_count(p_vc), .signature(p_sig)
   );

   alu_bist_driver #(.NUM_VECTORS(2), .SETTLE_CYCLES(1), .GOLDEN_SIG(32'h0)) dut_f (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ALU_BIST_ABORT_EN
      .abort(abort_off),
`endif
      .busy(f_busy), .done(f_done), .pass(f_pass),
      .alu_A(f_A), .alu_B(f_B), .alu_OpCode(f_op),
      .alu_Result(32'h8000_0000), .alu_Cout(1'b0), .alu_ZeroFlag(1'b0),
      .alu_OverflowFlag(1'b0), .alu_SLTFlag(1'b0),
      .vec_count(f_vc), .signature(f_sig)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      ecount++;
   endtask

   task automatic wait_vc(input logic [15:0] tgt, input int budget);
      int n = 0;
      while (d_vc !== tgt && n < budget) begin
         tick();
         n++;
      end
      chk("wait_vec_count", {16'h0, d_vc}, {16'h0, tgt});
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (d_done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk("wait_done", {31'h0, d_done}, 32'h1);
   endtask

   typedef struct {
      logic        busy;
      logic        done;
      logic [15:0] vc;
      logic [31:0] sig;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } step_t;

   step_t tbl[6];

   initial begin
      logic [31:0] ma, mb, msig, first_sig;
      logic [35:0] r;

      // Per-edge trace of the two-vector run with Result=80000000, flags 0.
      tbl[0] = '{1'b1, 1'b0, 16'd0, 32'h0000_0000, 4'd0, SA, SB};
      tbl[1] = '{1'b1, 1'b0, 16'd0, 32'h0000_0000, 4'd0, SA, SB};
      tbl[2] = '{1'b1, 1'b0, 16'd1, 32'h8000_0000, 4'd1, 32'hCA9A_54C3, 32'h0F9A_5EC3};
      tbl[3] = '{1'b1, 1'b0, 16'd1, 32'h8000_0000, 4'd1, 32'hCA9A_54C3, 32'h0F9A_5EC3};
      tbl[4] = '{1'b1, 1'b0, 16'd2, 32'h8040_0007, 4'd2, 32'h9574_A981, 32'h1F34_BD86};
      tbl[5] = '{1'b0, 1'b1, 16'd2, 32'h8040_0007, 4'd2, 32'h9574_A981, 32'h1F34_BD86};

      // Expected 48-vector signature for the behavioural ALU.
      ma = SA; mb = SB; msig = 32'h0;
      for (int i = 0; i < 48; i++) begin
         r    = alu_fn(ma, mb, 4'(i));
         msig = shf(msig) ^ r[31:0] ^ {28'h0, r[35:32]};
         ma   = shf(ma);
         mb   = shf(mb);
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, d_busy}, 32'h0);
      chk("rst_done", {31'h0, d_done}, 32'h0);
      chk("rst_pass", {31'h0, d_pass}, 32'h0);
      chk("rst_A", d_A, SA);
      chk("rst_B", d_B, SB);
      chk("rst_op", {28'h0, d_op}, 32'h0);
      chk("rst_vc", {16'h0, d_vc}, 32'h0);
      chk("rst_sig", d_sig, 32'h0);
      rst_n = 1'b1;
      tick();
      chk("idle_hold_busy", {31'h0, d_busy}, 32'h0);

      // First run: all three instances start together
      ecount = 0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         chk($sformatf("short_busy_e%0d", ecount), {31'h0, p_busy}, {31'h0, tbl[k].busy});
         chk($sformatf("short_done_e%0d", ecount), {31'h0, p_done}, {31'h0, tbl[k].done});
         chk($sformatf("short_vc_e%0d", ecount), {16'h0, p_vc}, {16'h0, tbl[k].vc});
         chk($sformatf("short_sig_e%0d", ecount), p_sig, tbl[k].sig);
         chk($sformatf("short_op_e%0d", ecount), {28'h0, p_op}, {28'h0, tbl[k].op});
         chk($sformatf("short_A_e%0d", ecount), p_A, tbl[k].a);
         chk($sformatf("short_B_e%0d", ecount), p_B, tbl[k].b);
      end
      chk("short_pass_golden", {31'h0, p_pass}, 32'h1);
      chk("short_done_nogold", {31'h0, f_done}, 32'h1);
      chk("short_pass_nogold", {31'h0, f_pass}, 32'h0);

      // Default run: done on edge 98
      while (ecount < 97) tick();
      chk("def_done_e97", {31'h0, d_done}, 32'h0);
      chk("def_busy_e97", {31'h0, d_busy}, 32'h1);
      tick();
      chk("def_done_e98", {31'h0, d_done}, 32'h1);
      chk("def_busy_e98", {31'h0, d_busy}, 32'h0);
      chk("def_vc", {16'h0, d_vc}, 32'd48);
      chk("def_sig", d_sig, msig);
      chk("def_pass", {31'h0, d_pass}, {31'h0, (msig == 32'h0)});
      chk("short_vc_saturated", {16'h0, p_vc}, 32'd2);
      chk("short_done_held", {31'h0, p_done}, 32'h1);
      first_sig = d_sig;

      // Second run: start clears done, signature repeats
      ecount = 0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk("rerun_done_cleared", {31'h0, d_done}, 32'h0);
      chk("rerun_busy", {31'h0, d_busy}, 32'h1);
      chk("rerun_vc_cleared", {16'h0, d_vc}, 32'h0);
      chk("rerun_sig_cleared", d_sig, 32'h0);
      chk("rerun_A_reloaded", d_A, SA);
      wait_done(200);
      chk("rerun_edges", ecount, 32'd98);
      chk("rerun_sig_repeat", d_sig, first_sig);

`ifdef ALU_BIST_ABORT_EN
      // Abort mid-run freezes counters and returns to IDLE
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_vc(16'd5, 100);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", {31'h0, d_busy}, 32'h0);
      chk("abort_done", {31'h0, d_done}, 32'h0);
      chk("abort_pass", {31'h0, d_pass}, 32'h0);
      chk("abort_vc", {16'h0, d_vc}, 32'd5);
      repeat (3) tick();
      chk("abort_idle_hold", {31'h0, d_busy}, 32'h0);
      chk("abort_vc_hold", {16'h0, d_vc}, 32'd5);
`endif

      // Mid-run: start ignored while busy, then asynchronous reset
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_vc(16'd10, 100);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_start_ignored", {31'h0, d_busy}, 32'h1);
      chk("busy_start_vc_kept", {31'h0, (d_vc >= 16'd10)}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'h0, d_busy}, 32'h0);
      chk("arst_done", {31'h0, d_done}, 32'h0);
      chk("arst_pass", {31'h0, d_pass}, 32'h0);
      chk("arst_A", d_A, SA);
      chk("arst_B", d_B, SB);
      chk("arst_op", {28'h0, d_op}, 32'h0);
      chk("arst_vc", {16'h0, d_vc}, 32'h0);
      chk("arst_sig", d_sig, 32'h0);
      #3 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
